// File: rtl/psk_deframer.sv
// BPSK/QPSK hard-decision deframer: hunts for a (possibly inverted) sync word,
// packs the following payload MSB-first into bytes and streams them through a small FIFO.
module psk_deframer #(
  parameter logic [31:0] SYNC_WORD     = 32'h1ACFFC1D,
  parameter int          SYNC_TOL      = 2,
  parameter int          PAYLOAD_BYTES = 64,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_qpsk,
  input  logic        BPSK,
  input  logic [1:0]  QPSK,
  input  logic        vld,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        locked,
  output logic        inverted,
  output logic        overflow,
  output logic [15:0] frame_cnt
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LAST_BYTE = 16'(PAYLOAD_BYTES - 1);
  localparam logic [5:0]  TOL       = 6'(SYNC_TOL);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {SEARCH, PAYLOAD} state_t;

  state_t        state_q, state_d;
  logic [31:0]   sr_q, sr_d;
  logic          inv_q, inv_d;
  logic          qm_q, qm_d;
  logic [7:0]    pk_q, pk_d;
  logic [2:0]    bc_q, bc_d;
  logic [15:0]   byc_q, byc_d;
  logic [15:0]   fc_q, fc_d;
  logic          push_q, push_d;
  logic [8:0]    pdata_q, pdata_d;
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [8:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic eff_mode, bit_in, done, pop, full, wr_en;

  function automatic logic [5:0] popcount32(input logic [31:0] x);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(x[i]);
    return n;
  endfunction

  // Up to two bits per cycle are walked in arrival order so that a sync hit on
  // the first QPSK bit hands the second bit straight to the payload packer.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    inv_d    = inv_q;
    qm_d     = qm_q;
    pk_d     = pk_q;
    bc_d     = bc_q;
    byc_d    = byc_q;
    fc_d     = fc_q;
    push_d   = 1'b0;
    pdata_d  = pdata_q;
    done     = 1'b0;
    bit_in   = 1'b0;
    eff_mode = (state_q == SEARCH) ? mode_qpsk : qm_q;
    for (int k = 0; k < 2; k++) begin
      if (vld && !done && (k == 0 || eff_mode)) begin
        bit_in = (k == 0) ? (eff_mode ? QPSK[1] : BPSK) : QPSK[0];
        if (state_d == SEARCH) begin
          sr_d = {sr_d[30:0], bit_in};
          if (popcount32(sr_d ^ SYNC_WORD) <= TOL) begin
            state_d = PAYLOAD;
            inv_d   = 1'b0;
            qm_d    = eff_mode;
            bc_d    = '0;
            byc_d   = '0;
          end else if (popcount32(sr_d ^ ~SYNC_WORD) <= TOL) begin
            state_d = PAYLOAD;
            inv_d   = 1'b1;
            qm_d    = eff_mode;
            bc_d    = '0;
            byc_d   = '0;
          end
        end else begin
          pk_d = {pk_d[6:0], bit_in ^ inv_d};
          if (bc_d == 3'd7) begin
            push_d  = 1'b1;
            pdata_d = {byc_d == LAST_BYTE, pk_d};
            if (byc_d == LAST_BYTE) begin
              state_d = SEARCH;
              sr_d    = '0;
              fc_d    = fc_d + 16'd1;
              byc_d   = '0;
              done    = 1'b1;
            end else begin
              byc_d = byc_d + 16'd1;
            end
          end
          bc_d = bc_d + 3'd1;
        end
      end
    end
  end

  // Output FIFO: a push into a full FIFO is dropped unless a pop frees a slot the same cycle.
  always_comb begin
    pop   = m_tvalid & m_tready;
    full  = (cnt_q == FULL_CNT);
    wr_en = push_q & (~full | pop);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q] = pdata_q;
    wr_d  = wr_q + AW'(wr_en);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    ovf_d = ovf_q | (push_q & full & ~pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEARCH;
      sr_q    <= '0;
      inv_q   <= 1'b0;
      qm_q    <= 1'b0;
      pk_q    <= '0;
      bc_q    <= '0;
      byc_q   <= '0;
      fc_q    <= '0;
      push_q  <= 1'b0;
      pdata_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      inv_q   <= inv_d;
      qm_q    <= qm_d;
      pk_q    <= pk_d;
      bc_q    <= bc_d;
      byc_q   <= byc_d;
      fc_q    <= fc_d;
      push_q  <= push_d;
      pdata_q <= pdata_d;
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign m_tvalid  = (cnt_q != '0);
  assign m_tdata   = mem_q[rd_q][7:0];
  assign m_tlast   = mem_q[rd_q][8];
  assign locked    = (state_q == PAYLOAD);
  assign inverted  = inv_q;
  assign overflow  = ovf_q;
  assign frame_cnt = fc_q;

endmodule
